// File: rtl/sel_encode_arbiter.sv
// Round-robin arbiter for the 8 word-line requests of the 8x8 array.
// Produces a registered 3-bit row address plus valid, held for a fixed window and followed by a one-cycle gap.
module sel_encode_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [7:0] i_req,
  output logic       o_adr0,
  output logic       o_adr1,
  output logic       o_adr2,
  output logic       o_valid,
  output logic [7:0] o_grant,
  output logic       o_done,
  output logic [1:0] dbgState
);

  // Handshake: none. o_valid qualifies {o_adr2,o_adr1,o_adr0} and o_grant for
  // the decoder; the decoder cannot stall, so there is no ready.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2
  } state_t;

  // A zero-length window is meaningless, so it is clamped to one cycle.
  localparam int              ACC_EFF  = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_EFF - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      lastPtr;
  logic [2:0]      adr;
  logic            winFound;
  logic [2:0]      winIdx;
  logic            arbGo;

  // Search upward from the slot after the last winner; the 3-bit sum wraps 7->0.
  always_comb begin
    winFound = 1'b0;
    winIdx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      if (!winFound && i_req[lastPtr + 3'(i)]) begin
        winFound = 1'b1;
        winIdx   = lastPtr + 3'(i);
      end
    end
  end

  assign arbGo = i_en && winFound;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lastPtr <= 3'd7;
      adr     <= 3'd0;
      o_valid <= 1'b0;
      o_grant <= 8'd0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (arbGo) begin
            adr     <= winIdx;
            o_grant <= 8'(1) << winIdx;
            o_valid <= 1'b1;
            cnt     <= CNT_LOAD;
            o_done  <= (CNT_LOAD == '0);
            state   <= ACCESS;
          end else begin
            o_valid <= 1'b0;
            o_grant <= 8'd0;
            o_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            o_valid <= 1'b0;
            o_grant <= 8'd0;
            o_done  <= 1'b0;
            lastPtr <= adr;
            state   <= GAP;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            o_done <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_grant <= 8'd0;
          o_done  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_adr0   = adr[0];
  assign o_adr1   = adr[1];
  assign o_adr2   = adr[2];
  assign dbgState = state;

endmodule

// File: tb/tb_sel_encode_arbiter.sv
// Self-checking bench for sel_encode_arbiter: directed scenarios plus random traffic
// compared every cycle against a window/pointer reference model.
module tb_sel_encode_arbiter;

  localparam int ACC = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       o_adr0, o_adr1, o_adr2, o_valid, o_done;
  logic [7:0] o_grant;
  logic [1:0] dbgState;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining high cycles of the current window, its row, and the pointer.
  int mLeft;
  int mCur;
  int mPtr;

  logic [2:0] exp_q[$];

  sel_encode_arbiter #(.ACCESS_CYCLES(ACC), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_req   (req),
    .o_adr0  (o_adr0),
    .o_adr1  (o_adr1),
    .o_adr2  (o_adr2),
    .o_valid (o_valid),
    .o_grant (o_grant),
    .o_done  (o_done),
    .dbgState(dbgState)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLeft = 0;
    mCur  = 0;
    mPtr  = 7;
  endtask

  task automatic modelEdge();
    bit found;
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) mPtr = mCur;
    end else if (en && req != 8'd0) begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && req[(mPtr + k) % 8]) begin
          found = 1;
          mCur  = (mPtr + k) % 8;
        end
      end
      mLeft = ACC;
    end
  endtask

  function automatic logic [2:0] adrNow();
    return {o_adr2, o_adr1, o_adr0};
  endfunction

  task automatic checkModel();
    check("m_adr",   32'(adrNow()), 32'(mCur));
    check("m_valid", 32'(o_valid), 32'(mLeft > 0));
    check("m_grant", 32'(o_grant), (mLeft > 0) ? (32'd1 << mCur) : 32'd0);
    check("m_done",  32'(o_done), 32'(mLeft == 1));
    check("onehot",  32'($countones(o_grant) <= 1), 32'd1);
  endtask

  // Driver: inputs change at the falling edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 modelReset();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_done",  32'(o_done), 32'd0);
    check("rst_adr",   32'(adrNow()), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int doneCnt;
    logic prevValid;
    logic [2:0] expAdr;

    rst_n = 1'b1;
    en    = 1'b0;
    req   = 8'd0;
    modelReset();
    #2 rst_n = 1'b0;
    #20;
    resetDut();

    // Sole requester 3: 2 high, done on the 2nd, 1 low, re-grant.
    @(negedge clk);
    en  = 1'b1;
    req = 8'h08;
    tick();
    check("t1_valid1", 32'(o_valid), 32'd1);
    check("t1_adr",    32'(adrNow()), 32'd3);
    check("t1_grant",  32'(o_grant), 32'h08);
    check("t1_done1",  32'(o_done), 32'd0);
    tick();
    check("t1_valid2", 32'(o_valid), 32'd1);
    check("t1_done2",  32'(o_done), 32'd1);
    tick();
    check("t1_gap",    32'(o_valid), 32'd0);
    tick();
    check("t1_regrant", 32'(o_valid), 32'd1);
    check("t1_readr",   32'(adrNow()), 32'd3);

    // All requesting from reset: order 0..7,0 and 8 done pulses in 24 cycles.
    resetDut();
    req = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    exp_q.push_back(3'd0);
    doneCnt   = 0;
    prevValid = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c <= 24 && o_done) doneCnt++;
      if (o_valid && !prevValid) begin
        if (exp_q.size() == 0) check("ff_extra_grant", 32'(adrNow()), 32'hFFFF);
        else begin
          expAdr = exp_q.pop_front();
          check("ff_order", 32'(adrNow()), 32'(expAdr));
        end
      end
      prevValid = o_valid;
    end
    check("ff_done_count", 32'(doneCnt), 32'd8);
    check("ff_queue_empty", 32'(exp_q.size()), 32'd0);

    // Wrap: grant 7, then 8'h81 gives 0 and then 7 again.
    resetDut();
    req = 8'h80;
    tick();
    check("wrap_first7", 32'(adrNow()), 32'd7);
    req = 8'h81;
    tick();
    tick();
    check("wrap_gap", 32'(o_valid), 32'd0);
    tick();
    check("wrap_to0", 32'(adrNow()), 32'd0);
    check("wrap_to0_v", 32'(o_valid), 32'd1);
    tick();
    tick();
    tick();
    check("wrap_back7", 32'(adrNow()), 32'd7);
    check("wrap_back7_g", 32'(o_grant), 32'h80);

    // Request dropped during the window: it still completes, then idles.
    req = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    req = 8'h10;
    tick();
    check("drop_grant", 32'(o_grant), 32'h10);
    req = 8'h00;
    tick();
    check("drop_hold", 32'(o_valid), 32'd1);
    check("drop_done", 32'(o_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop_low", 32'(o_valid), 32'd0);
    end

    // Enable low blocks grants; raising it grants on the next edge.
    en  = 1'b0;
    req = 8'h04;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("en_block", 32'(o_valid), 32'd0);
    end
    en = 1'b1;
    tick();
    check("en_grant_v", 32'(o_valid), 32'd1);
    check("en_grant_a", 32'(adrNow()), 32'd2);

    // Asynchronous reset inside the window clears outputs without a clock.
    #2 rst_n = 1'b0;
    #1 modelReset();
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_grant", 32'(o_grant), 32'd0);
    check("arst_done",  32'(o_done), 32'd0);
    req = 8'h30;
    #1 rst_n = 1'b1;
    tick();
    check("arst_lowest", 32'(adrNow()), 32'd4);
    check("arst_lowest_v", 32'(o_valid), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom_range(0, 255));
        1: req = 8'($urandom) & 8'($urandom);
        2: req = 8'd1 << $urandom_range(0, 7);
        default: req = req;
      endcase
      en = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sel_encode_arbiter.md
Name: sel_encode_arbiter

Overview:
Request side of the row-select path. Takes 8 word-line request lines and arbitrates them round-robin. Drives the 3-bit binary address plus valid that feed the 3-to-8 select decoder of the 8x8 memory array. Each grant is held for a fixed access window, followed by a mandatory one-cycle valid-low gap so two rows are never selected back-to-back without a break.

Parameters:
ACCESS_CYCLES, 2, cycles o_valid stays high per grant; legal 1..15; 0 is treated as 1.
CNT_W, 4, width of the access down-counter; must hold ACCESS_CYCLES-1.

Ports:
i_clk  input  1  clock, rising-edge.
i_rst_n  input  1  reset; asynchronous, active-low.
i_en  input  1  arbitration enable; low blocks new grants only.
i_req  input  8  request per word; bit n requests address n; level-sensitive.
o_adr0  output  1  granted address bit 0 (to decoder i_adr0).
o_adr1  output  1  granted address bit 1 (to decoder i_adr1).
o_adr2  output  1  granted address bit 2 (to decoder i_adr2).
o_valid  output  1  address valid (to decoder valid).
o_grant  output  8  one-hot copy of the current grant; all-zero when o_valid=0.
o_done  output  1  one-cycle pulse on the last cycle of an access window.

Behaviour:
- All outputs are registered.
- Reset (i_rst_n=0, asynchronous):
  - o_adr0/1/2=0, o_valid=0, o_grant=0, o_done=0.
  - State=IDLE, counter=0, last-granted pointer=7, so after reset index 0 has highest priority.
- Reset is honoured immediately in any state. Mid-access it drops o_valid without waiting for a clock; no o_done is produced.
- FSM states: IDLE, ACCESS, GAP.
- Arbitration (IDLE and GAP):
  - Evaluated on each rising edge while in IDLE or GAP, with i_en=1 and i_req!=0.
  - Winner is the first set bit searching upward from (last+1) mod 8, wrapping 7->0.
  - On that edge: address bits are loaded with the winner index, o_grant=1<<winner, o_valid=1, counter=ACCESS_CYCLES-1, next state ACCESS.
  - Latency: a request present before edge k in IDLE gives o_valid=1 after edge k (1 cycle).
- IDLE, no winner: stay IDLE; o_valid=0; address bits hold their last value.
- ACCESS:
  - Address, o_grant and o_valid=1 held stable.
  - Counter decrements each edge.
  - o_done=1 during the cycle where counter==0.
  - On the edge leaving counter==0: o_valid=0, o_grant=0, o_done=0, last=winner, next state GAP.
- GAP: exactly one cycle with o_valid=0.
  - Arbitration runs on the GAP-exit edge.
  - With a winner: next state ACCESS. Back-to-back grants are therefore separated by exactly 1 low cycle.
  - Without a winner: next state IDLE.
- Request dropped during ACCESS: the window still runs to completion. Memory timing is fixed; there is no abort.
- The granted requester re-asserting is not re-granted until every other active requester has been served, because the pointer moved past it.
- i_en=0: no new grant in IDLE or GAP. An in-progress ACCESS completes normally.
- Address bits change only on a grant edge, so they never glitch while o_valid=1.
- Invariants:
  - popcount(o_grant)<=1.
  - o_grant!=0 iff o_valid=1.
  - {o_adr2,o_adr1,o_adr0} equals the index of o_grant whenever o_valid=1.

Test Plan:
- Reset, then i_en=1, i_req=8'h08 held -> o_valid rises 1 cycle later with adr=3 and o_grant=8'h08. Valid is high 2 cycles, o_done pulses on the 2nd, then 1 low cycle, then adr=3 is re-granted (sole requester).
- i_req=8'hFF held from reset -> grant order is 0,1,2,…,7,0 with adr stepping 0..7. Pattern is 2 high / 1 low per grant, and o_done fires 8 times per 24 cycles.
- i_req=8'h81 after a grant to 7 -> next grant is 0 (wrap). The following grant is 7, confirming pointer rotation.
- i_req=8'h10 drops to 0 in the first ACCESS cycle -> the window still completes (o_valid high 2 cycles), then the block goes GAP -> IDLE with o_valid low.
- i_en=0 with i_req=8'h04 -> no grant for 10 cycles. i_en raised -> grant adr=2 on the next edge.
- i_rst_n pulled low mid-ACCESS (between clock edges) -> o_valid, o_grant and o_done go 0 immediately. After release, the first grant goes to the lowest active index.
